// File: rtl/bus_pkg.sv
// bus_pkg: dispatch state encoding and caster_en bit positions
package bus_pkg;
  typedef enum logic [2:0] {IDLE, LD_IF, LD_FL, LD_PS, WAIT, DRAIN, DONE} state_t;
  localparam int CASTER_IFMAP = 0;
  localparam int CASTER_FLTR = 1;
  localparam int CASTER_PSUM = 2;
endpackage

// File: rtl/bus_res_reg.sv
// bus_res_reg: holds one column result and presents it on the vld/rdy result port
module bus_res_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cap,
  input  logic [W-1:0] cap_dat,
  input  logic         show,
  input  logic         res_rdy,
  output logic         res_vld,
  output logic [W-1:0] res_dat,
  output logic         acc
);
  // result stays stable from capture until the next capture
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) res_dat <= '0;
    else if (cap) res_dat <= cap_dat;
  assign res_vld = show;
  assign acc = show & res_rdy;
endmodule

// File: rtl/bus_dispatcher.sv
// bus_dispatcher: loads ifmap/fltr/psum per column into the casters and returns results; DISPATCH_TIMEOUT_EN adds a WAIT timeout
module bus_dispatcher
  import bus_pkg::*;
#(
  parameter  int DATA_WIDTH  = 16,
  parameter  int NUM_COL     = 4,
  parameter  int TIMEOUT_CYC = 256,
  localparam int CW = NUM_COL > 1 ? $clog2(NUM_COL) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    ifmap_vld,
  output logic                    ifmap_rdy,
  input  logic [DATA_WIDTH-1:0]   ifmap_dat,
  input  logic                    fltr_vld,
  output logic                    fltr_rdy,
  input  logic [DATA_WIDTH-1:0]   fltr_dat,
  input  logic                    psum_vld,
  output logic                    psum_rdy,
  input  logic [2*DATA_WIDTH-1:0] psum_dat,
  output logic [2:0]              caster_en,
  output logic [DATA_WIDTH-1:0]   ifmap_b2m,
  output logic [DATA_WIDTH-1:0]   fltr_b2m,
  output logic [2*DATA_WIDTH-1:0] psum_b2m,
  input  logic                    caster_ready,
  input  logic                    caster_valid,
  input  logic [2*DATA_WIDTH-1:0] psum_m2b,
  output logic                    res_vld,
  input  logic                    res_rdy,
  output logic [2*DATA_WIDTH-1:0] res_dat,
  output logic [CW-1:0]           col_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  state_t state, nxt;
  logic [CW-1:0] col;
  logic if_x, fl_x, ps_x, cap, acc, tmo, last;
  logic [DATA_WIDTH-1:0] if_q, fl_q;
  logic [2*DATA_WIDTH-1:0] ps_q;
  assign if_x = state == LD_IF && ifmap_vld && caster_ready;
  assign fl_x = state == LD_FL && fltr_vld && caster_ready;
  assign ps_x = state == LD_PS && psum_vld && caster_ready;
  assign last = col == CW'(NUM_COL - 1);
  assign cap = state == WAIT && (caster_valid || tmo);
  assign ifmap_rdy = if_x;
  assign fltr_rdy = fl_x;
  assign psum_rdy = ps_x;
  assign ifmap_b2m = if_x ? ifmap_dat : if_q;
  assign fltr_b2m = fl_x ? fltr_dat : fl_q;
  assign psum_b2m = ps_x ? psum_dat : ps_q;
  assign col_sel = col;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // one-hot caster enable, only during the transfer cycle of each load
  always_comb begin
    caster_en = '0;
    caster_en[CASTER_IFMAP] = if_x;
    caster_en[CASTER_FLTR] = fl_x;
    caster_en[CASTER_PSUM] = ps_x;
  end
  // next-state: each stage advances only on its own handshake
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LD_IF : IDLE;
      LD_IF:   nxt = if_x ? LD_FL : LD_IF;
      LD_FL:   nxt = fl_x ? LD_PS : LD_FL;
      LD_PS:   nxt = ps_x ? WAIT : LD_PS;
      WAIT:    nxt = cap ? DRAIN : WAIT;
      DRAIN:   nxt = acc ? (last ? DONE : LD_IF) : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // state, column counter and last-transferred words held for the casters
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      col <= '0;
      if_q <= '0;
      fl_q <= '0;
      ps_q <= '0;
    end else begin
      state <= nxt;
      if (if_x) if_q <= ifmap_dat;
      if (fl_x) fl_q <= fltr_dat;
      if (ps_x) ps_q <= psum_dat;
      if (acc) col <= last ? '0 : col + CW'(1);
    end
`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] cnt;
  assign tmo = state == WAIT && !caster_valid && cnt == TW'(TIMEOUT_CYC - 1);
  // WAIT cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + TW'(1) : '0;
      err <= err | tmo;
    end
`else
  assign tmo = TIMEOUT_CYC < 0;
  assign err = 1'b0;
`endif
  bus_res_reg #(.W(2 * DATA_WIDTH)) u_res (
    .clk     (clk),
    .rstn    (rstn),
    .cap     (cap),
    .cap_dat (tmo ? '0 : psum_m2b),
    .show    (state == DRAIN),
    .res_rdy (res_rdy),
    .res_vld (res_vld),
    .res_dat (res_dat),
    .acc     (acc)
  );
endmodule

// File: tb/tb_bus_dispatcher.sv
// tb_bus_dispatcher: scoreboard bench for bus_dispatcher (timeout pass runs when DISPATCH_TIMEOUT_EN is defined)
module tb_bus_dispatcher;
  logic clk = 0, rstn = 0, start = 0;
  logic ifmap_vld = 0, fltr_vld = 0, psum_vld = 0;
  logic ifmap_rdy, fltr_rdy, psum_rdy;
  logic [15:0] ifmap_dat = 0, fltr_dat = 0, ifmap_b2m, fltr_b2m;
  logic [31:0] psum_dat = 0, psum_b2m, psum_m2b = 0, res_dat;
  logic [2:0] caster_en;
  logic caster_ready = 0, caster_valid = 0, res_vld, res_rdy = 0;
  logic [1:0] col_sel;
  logic busy, done, err;
  logic [15:0] last_if, last_fl;
  logic [31:0] last_ps;
  logic [31:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  bus_dispatcher #(.DATA_WIDTH(16), .NUM_COL(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .ifmap_vld(ifmap_vld), .ifmap_rdy(ifmap_rdy), .ifmap_dat(ifmap_dat),
    .fltr_vld(fltr_vld), .fltr_rdy(fltr_rdy), .fltr_dat(fltr_dat),
    .psum_vld(psum_vld), .psum_rdy(psum_rdy), .psum_dat(psum_dat),
    .caster_en(caster_en), .ifmap_b2m(ifmap_b2m), .fltr_b2m(fltr_b2m), .psum_b2m(psum_b2m),
    .caster_ready(caster_ready), .caster_valid(caster_valid), .psum_m2b(psum_m2b),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_dat(res_dat),
    .col_sel(col_sel), .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_ready();
    ifmap_vld = 1;
    fltr_vld = 1;
    psum_vld = 1;
    caster_ready = 1;
    res_rdy = 1;
  endtask
  task automatic col_fast(input int col);
    for (int p = 0; p < 5; p++) begin
      ifmap_dat = 16'($urandom);
      fltr_dat = 16'($urandom);
      psum_dat = $urandom;
      psum_m2b = $urandom;
      caster_valid = 1;
      if (p == 3) exp_q.push_back(psum_m2b);
      #1;
      chk("caster_en", 32'(caster_en), p < 3 ? 32'(1) << p : 32'd0);
      chk("col_sel", 32'(col_sel), 32'(col));
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), 0);
      chk("res_vld", 32'(res_vld), 32'(p == 4));
      if (p == 0) begin
        chk("ifmap_b2m", 32'(ifmap_b2m), 32'(ifmap_dat));
        chk("ifmap_rdy", 32'(ifmap_rdy), 1);
        last_if = ifmap_dat;
      end
      if (p == 1) begin
        chk("fltr_b2m", 32'(fltr_b2m), 32'(fltr_dat));
        chk("fltr_rdy", 32'(fltr_rdy), 1);
        last_fl = fltr_dat;
      end
      if (p == 2) begin
        chk("psum_b2m", psum_b2m, psum_dat);
        chk("psum_rdy", 32'(psum_rdy), 1);
        last_ps = psum_dat;
      end
      tick();
    end
  endtask
  task automatic chk_done();
    #1;
    chk("done_pulse", 32'(done), 1);
    chk("done_col", 32'(col_sel), 0);
    chk("done_en", 32'(caster_en), 0);
    tick();
    #1;
    chk("done_end", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("q_empty", 32'(exp_q.size()), 0);
  endtask
  always @(negedge clk) begin
    #2;
    if (rstn && res_vld && res_rdy) begin
      chk("res_q", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("res_dat", res_dat, exp_q.pop_front());
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    start = 1;
    set_ready();
    caster_valid = 1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(caster_en), 0);
    chk("rst_rdy", 32'({ifmap_rdy, fltr_rdy, psum_rdy}), 0);
    tick();
    #1;
    chk("rst_wins", 32'(busy), 0);
    chk("rst_out", {res_vld, done, err, col_sel, res_dat[26:0]}, 0);
    chk("rst_b2m", 32'(ifmap_b2m) | 32'(fltr_b2m) | psum_b2m, 0);
    start = 0;
    tick();
    rstn = 1;
    tick();
    // full pass, everything ready: 5 cycles per column, done at cycle 21
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 4; c++) col_fast(c);
    chk_done();
    // ifmap stall, caster stall in LD_PS, held result
    start = 1;
    tick();
    ifmap_vld = 0;
    caster_valid = 0;
    repeat (3) begin
      ifmap_dat = 16'($urandom);
      #1;
      chk("if_stall_en", 32'(caster_en), 0);
      chk("if_stall_rdy", 32'(ifmap_rdy), 0);
      chk("if_hold", 32'(ifmap_b2m), 32'(last_if));
      chk("if_busy", 32'(busy), 1);
      tick();
    end
    start = 0;
    ifmap_vld = 1;
    #1;
    chk("if_go_en", 32'(caster_en), 1);
    chk("if_go_b2m", 32'(ifmap_b2m), 32'(ifmap_dat));
    tick();
    #1;
    chk("fl_en", 32'(caster_en), 2);
    tick();
    caster_ready = 0;
    psum_dat = $urandom;
    repeat (2) begin
      #1;
      chk("ps_stall_en", 32'(caster_en), 0);
      chk("ps_stall_rdy", 32'(psum_rdy), 0);
      chk("ps_hold", psum_b2m, last_ps);
      tick();
    end
    caster_ready = 1;
    #1;
    chk("ps_go_en", 32'(caster_en), 4);
    chk("ps_go_b2m", psum_b2m, psum_dat);
    tick();
    #1;
    chk("wait_idle", 32'({caster_en, res_vld}), 0);
    tick();
    caster_valid = 1;
    psum_m2b = 32'hDEAD_BEEF;
    exp_q.push_back(psum_m2b);
    tick();
    res_rdy = 0;
    repeat (4) begin
      psum_m2b = $urandom;
      #1;
      chk("drain_vld", 32'(res_vld), 1);
      chk("drain_dat", res_dat, 32'hDEAD_BEEF);
      chk("drain_col", 32'(col_sel), 0);
      tick();
    end
    res_rdy = 1;
    #1;
    chk("drain_acc", 32'(res_vld), 1);
    tick();
    for (int c = 1; c < 4; c++) col_fast(c);
    chk_done();
    // asynchronous reset while waiting in column 2
    start = 1;
    tick();
    start = 0;
    col_fast(0);
    col_fast(1);
    caster_valid = 0;
    repeat (3) tick();
    #1;
    chk("mid_col", 32'(col_sel), 2);
    rstn = 0;
    #1;
    chk("mid_rst", {busy, done, err, res_vld, caster_en, col_sel}, 0);
    chk("mid_rst_dat", res_dat | psum_b2m | 32'(ifmap_b2m) | 32'(fltr_b2m), 0);
    tick();
    rstn = 1;
    tick();
    #1;
    chk("mid_idle", 32'({busy, done}), 0);
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 4; c++) col_fast(c);
    chk_done();
`ifdef DISPATCH_TIMEOUT_EN
    // result never arrives: each column times out after 8 WAIT cycles
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 4; c++) begin
      caster_valid = 0;
      repeat (3) tick();
      repeat (8) begin
        #1;
        chk("to_wait_err", 32'(err), 32'(c > 0));
        chk("to_wait_vld", 32'(res_vld), 0);
        tick();
      end
      exp_q.push_back(0);
      #1;
      chk("to_err", 32'(err), 1);
      chk("to_res", res_dat, 0);
      chk("to_vld", 32'(res_vld), 1);
      tick();
    end
    chk_done();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
